// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its Execute-result buffer.
package wb_arbiter_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] regdest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of Execute results with a regdest-matched kill port.
// Depth need not be a power of two; pointers wrap explicitly.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  input  logic                 kill,
  input  logic [WB_ADDR_W-1:0] kill_regdest,
  output wb_entry_t            head_entry,
  output logic [CNT_W-1:0]     count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic                 valid_q   [DEPTH];
  logic [WB_ADDR_W-1:0] regdest_q [DEPTH];
  logic [WB_DATA_W-1:0] data_q    [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;

  logic push_ok;
  logic pop_ok;

  assign push_ok = push && (count != FULL_CNT);
  assign pop_ok  = pop && (count != '0);

  assign head_entry = '{valid: valid_q[head], regdest: regdest_q[head], data: data_q[head]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the later push assignment wins over a kill.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else begin
      // Kill looks only at entries already stored; a same-cycle push is younger.
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (regdest_q[i] == kill_regdest) valid_q[i] <= 1'b0;
        end
      end
      if (push_ok) begin
        valid_q[tail] <= push_entry.valid;
        tail          <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      end
      if (pop_ok) head <= (head == LAST_PTR) ? '0 : head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage carries no reset; valid bits and count alone decide
  // whether a slot means anything, so clearing the data would only cost logic.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      regdest_q[tail] <= push_entry.regdest;
      data_q[tail]    <= push_entry.data;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: Mem always wins the single register-file write port,
// Execute results queue in order behind it. Optional WB_OVERFLOW_CHECK_EN adds wb_overflow.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_wb_writereg,
  input  logic [WB_ADDR_W-1:0] mem_wb_regdest,
  input  logic [WB_DATA_W-1:0] mem_wb_wbvalue,
  input  logic                 ex_wb_writereg,
  input  logic [WB_ADDR_W-1:0] ex_wb_regdest,
  input  logic [WB_DATA_W-1:0] ex_wb_wbvalue,
  output logic                 wb_ex_stall,
  output logic                 wb_rf_writeenable,
  output logic [WB_ADDR_W-1:0] wb_rf_writeaddr,
  output logic [WB_DATA_W-1:0] wb_rf_writedata
`ifdef WB_OVERFLOW_CHECK_EN
  ,
  output logic                 wb_overflow
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic                 mem_ok;
  logic                 ex_ok;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  wb_entry_t            head_entry;
  wb_entry_t            push_entry;
  logic                 push;
  logic                 pop;
  logic                 sel_we;
  logic [WB_ADDR_W-1:0] sel_addr;
  logic [WB_DATA_W-1:0] sel_data;

  assign wb_ex_stall = (fifo_count == FULL_CNT);
  assign fifo_empty  = (fifo_count == '0);
  assign mem_ok      = mem_wb_writereg && (mem_wb_regdest != REG_ZERO);
  // An Execute result offered while stalled is illegal and is dropped here.
  assign ex_ok       = ex_wb_writereg && (ex_wb_regdest != REG_ZERO) && !wb_ex_stall;
  assign push_entry  = '{valid: 1'b1, regdest: ex_wb_regdest, data: ex_wb_wbvalue};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = mem_wb_regdest;
    sel_data = mem_wb_wbvalue;
    pop      = 1'b0;
    push     = 1'b0;
    if (mem_ok) begin
      sel_we = 1'b1;
      push   = ex_ok;
    end else if (!fifo_empty) begin
      pop      = 1'b1;
      sel_we   = head_entry.valid;
      sel_addr = head_entry.regdest;
      sel_data = head_entry.data;
      push     = ex_ok;
    end else if (ex_ok) begin
      sel_we   = 1'b1;
      sel_addr = ex_wb_regdest;
      sel_data = ex_wb_wbvalue;
    end
  end

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .kill         (mem_ok),
    .kill_regdest (mem_wb_regdest),
    .head_entry   (head_entry),
    .count        (fifo_count)
  );

  // Address and data hold their last value while no write is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_rf_writeenable <= 1'b0;
      wb_rf_writeaddr   <= '0;
      wb_rf_writedata   <= '0;
    end else begin
      wb_rf_writeenable <= sel_we;
      if (sel_we) begin
        wb_rf_writeaddr <= sel_addr;
        wb_rf_writedata <= sel_data;
      end
    end
  end

`ifdef WB_OVERFLOW_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) wb_overflow <= 1'b0;
    else if (ex_wb_writereg && wb_ex_stall) wb_overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// cycle's register-file outputs, a separate monitor compares them after the edge.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_wb_writereg;
  logic [4:0]  mem_wb_regdest;
  logic [31:0] mem_wb_wbvalue;
  logic        ex_wb_writereg;
  logic [4:0]  ex_wb_regdest;
  logic [31:0] ex_wb_wbvalue;
  logic        wb_ex_stall;
  logic        wb_rf_writeenable;
  logic [4:0]  wb_rf_writeaddr;
  logic [31:0] wb_rf_writedata;
`ifdef WB_OVERFLOW_CHECK_EN
  logic        wb_overflow;
`endif

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .mem_wb_writereg   (mem_wb_writereg),
    .mem_wb_regdest    (mem_wb_regdest),
    .mem_wb_wbvalue    (mem_wb_wbvalue),
    .ex_wb_writereg    (ex_wb_writereg),
    .ex_wb_regdest     (ex_wb_regdest),
    .ex_wb_wbvalue     (ex_wb_wbvalue),
    .wb_ex_stall       (wb_ex_stall),
    .wb_rf_writeenable (wb_rf_writeenable),
    .wb_rf_writeaddr   (wb_rf_writeaddr),
    .wb_rf_writedata   (wb_rf_writedata)
`ifdef WB_OVERFLOW_CHECK_EN
    ,
    .wb_overflow       (wb_overflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        ovf;
  } exp_t;

  ent_t        model_q [$];
  exp_t        exp_q   [$];
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  logic        model_ovf;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs on the falling edge, advance the model,
  // and queue the outputs expected right after the next rising edge.
  task automatic cycle(input logic rst,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic ev, input logic [4:0] erd, input logic [31:0] ed);
    exp_t e;
    logic stall, mem_ok, ex_ok, direct, had_entries;
    ent_t h;
    @(negedge clock);
    reset = rst;
    mem_wb_writereg = mv; mem_wb_regdest = mrd; mem_wb_wbvalue = md;
    ex_wb_writereg  = ev; ex_wb_regdest  = erd; ex_wb_wbvalue  = ed;
    e.we = 1'b0;
    if (rst) begin
      model_q.delete();
      last_addr = '0;
      last_data = '0;
      model_ovf = 1'b0;
    end else begin
      stall       = (model_q.size() == DEPTH);
      if (ev && stall) model_ovf = 1'b1;
      mem_ok      = mv && (mrd != 5'd0);
      ex_ok       = ev && (erd != 5'd0) && !stall;
      direct      = 1'b0;
      had_entries = (model_q.size() != 0);
      if (mem_ok) begin
        e.we = 1'b1; last_addr = mrd; last_data = md;
        foreach (model_q[i]) if (model_q[i].rd == mrd) model_q[i].valid = 1'b0;
      end else if (had_entries) begin
        h = model_q.pop_front();
        if (h.valid) begin e.we = 1'b1; last_addr = h.rd; last_data = h.d; end
      end else if (ex_ok) begin
        e.we = 1'b1; last_addr = erd; last_data = ed; direct = 1'b1;
      end
      if (ex_ok && !direct) model_q.push_back('{valid: 1'b1, rd: erd, d: ed});
    end
    e.addr  = last_addr;
    e.data  = last_data;
    e.stall = (model_q.size() == DEPTH);
    e.ovf   = model_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: pops one expectation per rising edge and compares just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("writeenable", 32'(wb_rf_writeenable), 32'(e.we));
        check("writeaddr",   32'(wb_rf_writeaddr),   32'(e.addr));
        check("writedata",   wb_rf_writedata,        e.data);
        check("ex_stall",    32'(wb_ex_stall),       32'(e.stall));
`ifdef WB_OVERFLOW_CHECK_EN
        check("overflow",    32'(wb_overflow),       32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    logic        mv, ev, rs;
    logic [4:0]  mrd, erd;
    int          wait_cycles;
    reset = 1'b1;
    mem_wb_writereg = 1'b0; mem_wb_regdest = '0; mem_wb_wbvalue = '0;
    ex_wb_writereg  = 1'b0; ex_wb_regdest  = '0; ex_wb_wbvalue  = '0;
    last_addr = '0; last_data = '0; model_ovf = 1'b0;

    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(1);

    // Mem-only write.
    cycle(1'b0, 1'b1, 5'd3, 32'hDEAD0001, 1'b0, 5'd0, 32'd0);
    idle(2);
    // Collision: Mem first, Execute one cycle later.
    cycle(1'b0, 1'b1, 5'd4, 32'h11, 1'b1, 5'd5, 32'h22);
    idle(3);
    // Fill to stall under continuous Mem traffic, then drain in order.
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, 5'(10 + i), 32'h100 + 32'(i),
            (i < 4), 5'(6 + i), 32'h600 + 32'(i));
    idle(6);
    // WAW kill: Execute r7 queued, then Mem r7 kills it, leaving one bubble.
    cycle(1'b0, 1'b1, 5'd1, 32'h01, 1'b1, 5'd7, 32'hAA);
    cycle(1'b0, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
    idle(3);
    // r0 inputs are discarded.
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    cycle(1'b0, 1'b1, 5'd0, 32'h56, 1'b0, 5'd0, 32'd0);
    idle(2);
    // Reset with three buffered entries.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 5'(20 + i), 32'h200 + 32'(i), 1'b1, 5'(24 + i), 32'h300 + 32'(i));
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);
    // Execute offered while stalled: dropped, flags overflow when enabled.
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, 5'(10 + i), 32'h400 + 32'(i), 1'b1, 5'(6 + i), 32'h500 + 32'(i));
    cycle(1'b0, 1'b1, 5'd15, 32'h415, 1'b1, 5'd11, 32'h511);
    idle(6);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(1);

    // Randomized traffic over a small register range to provoke kills.
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 199) == 0);
      mv  = ($urandom_range(0, 99) < 45);
      ev  = ($urandom_range(0, 99) < 60);
      if (model_q.size() == DEPTH && $urandom_range(0, 49) != 0) ev = 1'b0;
      mrd = 5'($urandom_range(0, 7));
      erd = 5'($urandom_range(0, 7));
      cycle(rs, mv, mrd, $urandom, ev, erd, $urandom);
    end

    wait_cycles = 0;
    while (model_q.size() != 0 && wait_cycles < 2 * DEPTH) begin
      idle(1);
      wait_cycles++;
    end
    idle(1);
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
